select_block_rr: RTL and testbench

Multi-grant, round-robin select block for the issue select tree. It replaces the single-grant, fixed-priority leaf. Each cycle it picks up to NUM_GRANTS requesters starting from a registered rotating pointer, and gates each grant slot with the matching grant from the next tree stage. The pointer advances past the last delivered grant, which gives starvation-free selection among ready issue-queue entries. A mode input restores legacy fixed priority (index 0 highest).

---
 rtl/select_pkg.sv | 17 +
 rtl/rr_find_first.sv | 33 +++
 rtl/select_block_rr.sv | 78 +++++++
 tb/tb_select_block_rr.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/select_pkg.sv
// Shared helpers for the round-robin select tree: pointer width derivation
// and the popcount threshold used to drive req_o toward the next stage.
package select_pkg;

    // Widest request vector the popcount helper accepts; callers zero-extend.
    localparam int MAX_SEL_SIZE = 256;

    function automatic int sel_ptr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic logic count_at_least(input logic [MAX_SEL_SIZE-1:0] vec,
                                            input int                      thresh);
        return $countones(vec) >= thresh;
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Circular find-first-set: scans mask starting at index 'start', wrapping
// from SIZE-1 back to 0, and reports the first set bit as one-hot and index.
module rr_find_first import select_pkg::*; #(
    parameter int SIZE  = 16,
    parameter int PTR_W = sel_ptr_width(SIZE)
) (
    input  logic [PTR_W-1:0] start,
    input  logic [SIZE-1:0]  mask,
    output logic [SIZE-1:0]  onehot,
    output logic [PTR_W-1:0] index,
    output logic             valid
);

    always_comb begin
        int pos;
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        pos    = 0;
        for (int i = 0; i < SIZE; i++) begin
            pos = int'(start) + i;
            if (pos >= SIZE) begin
                pos = pos - SIZE;
            end
            if (!valid && mask[pos]) begin
                valid       = 1'b1;
                onehot[pos] = 1'b1;
                index       = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/select_block_rr.sv
// Multi-grant round-robin select leaf: picks up to NUM_GRANTS requesters from a
// rotating pointer, gates each slot with the downstream grant, advances the pointer.
module select_block_rr import select_pkg::*; #(
    parameter  int SIZE_SELECT_BLOCK = 16,
    parameter  int NUM_GRANTS        = 2,
    localparam int PTR_W             = sel_ptr_width(SIZE_SELECT_BLOCK)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          rrEn_i,
    input  logic [SIZE_SELECT_BLOCK-1:0]                  req_i,
    input  logic [NUM_GRANTS-1:0]                         grant_i,
    output logic [NUM_GRANTS-1:0][SIZE_SELECT_BLOCK-1:0]  grant_o,
    output logic [NUM_GRANTS-1:0]                         req_o,
    output logic [PTR_W-1:0]                              ptr_o
);

    logic [PTR_W-1:0]             ptr;
    logic [PTR_W-1:0]             ptr_next;
    logic [PTR_W-1:0]             scan_start;
    logic [SIZE_SELECT_BLOCK-1:0] stage_mask [NUM_GRANTS];
    logic [SIZE_SELECT_BLOCK-1:0] cand       [NUM_GRANTS];
    logic [PTR_W-1:0]             cand_idx   [NUM_GRANTS];
    logic [NUM_GRANTS-1:0]        cand_valid;
    logic                         delivered;
    logic [MAX_SEL_SIZE-1:0]      req_ext;

    assign scan_start = rrEn_i ? ptr : '0;
    assign req_ext    = MAX_SEL_SIZE'(req_i);

    // Each slot searches what the earlier slots left behind, so candidates
    // come out mutually exclusive and in scan order.
    for (genvar k = 0; k < NUM_GRANTS; k++) begin : g_slot
        if (k == 0) begin : g_first
            assign stage_mask[k] = req_i;
        end else begin : g_next
            assign stage_mask[k] = stage_mask[k-1] & ~cand[k-1];
        end

        rr_find_first #(
            .SIZE  (SIZE_SELECT_BLOCK),
            .PTR_W (PTR_W)
        ) u_find (
            .start  (scan_start),
            .mask   (stage_mask[k]),
            .onehot (cand[k]),
            .index  (cand_idx[k]),
            .valid  (cand_valid[k])
        );

        assign grant_o[k] = (reset || !grant_i[k]) ? '0 : cand[k];
        assign req_o[k]   = count_at_least(req_ext, k + 1);
    end

    // Later slots are later in scan order, so the last delivered slot wins.
    always_comb begin
        delivered = 1'b0;
        ptr_next  = ptr;
        for (int k = 0; k < NUM_GRANTS; k++) begin
            if (cand_valid[k] && grant_i[k]) begin
                delivered = 1'b1;
                ptr_next  = (cand_idx[k] == PTR_W'(SIZE_SELECT_BLOCK - 1)) ?
                            '0 : cand_idx[k] + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (rrEn_i && delivered) begin
            ptr <= ptr_next;
        end
    end

    assign ptr_o = ptr;

endmodule

// File: tb/tb_select_block_rr.sv
// Bench for select_block_rr (8 requesters, 2 slots): directed steps, random
// steps against a scan-order reference model, and a fairness bound run.
module tb_select_block_rr;

    localparam int SIZE = 8;
    localparam int NG   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            rrEn_i;
    logic [7:0]      req_i;
    logic [1:0]      grant_i;
    logic [1:0][7:0] grant_o;
    logic [1:0]      req_o;
    logic [2:0]      ptr_o;

    int errors = 0;
    int checks = 0;

    int              m_ptr;
    int              exp_next;
    logic [1:0][7:0] exp_grant;
    logic [1:0]      exp_req;

    bit fair_on = 1'b0;
    int wait_cnt [SIZE];
    int max_wait = 0;

    select_block_rr #(
        .SIZE_SELECT_BLOCK (SIZE),
        .NUM_GRANTS        (NG)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rrEn_i  (rrEn_i),
        .req_i   (req_i),
        .grant_i (grant_i),
        .grant_o (grant_o),
        .req_o   (req_o),
        .ptr_o   (ptr_o)
    );

    always #5 clk = ~clk;

    // Reference: walk the ring from the start index, take the first NG requesters.
    task automatic modelCompute(input logic rst, input logic en,
                                input logic [7:0] req, input logic [1:0] gnt);
        int picks[$];
        int start;
        int cnt;
        start = en ? m_ptr : 0;
        for (int i = 0; i < SIZE; i++) begin
            int p;
            p = (start + i) % SIZE;
            if (req[p] && picks.size() < NG) picks.push_back(p);
        end
        exp_grant = '0;
        exp_next  = m_ptr;
        for (int k = 0; k < picks.size(); k++) begin
            if (!rst && gnt[k]) begin
                exp_grant[k] = 8'(1) << picks[k];
                if (en) exp_next = (picks[k] + 1) % SIZE;
            end
        end
        if (rst) exp_next = 0;
        cnt = 0;
        for (int i = 0; i < SIZE; i++) if (req[i]) cnt++;
        exp_req[0] = (cnt >= 1);
        exp_req[1] = (cnt >= 2);
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (grant_o === exp_grant) else begin
            errors++;
            $error("[TB] FAIL %s grant_o: got %h expected %h", tag, grant_o, exp_grant);
        end
        checks++;
        assert (req_o === exp_req) else begin
            errors++;
            $error("[TB] FAIL %s req_o: got %b expected %b", tag, req_o, exp_req);
        end
        checks++;
        assert (ptr_o === 3'(m_ptr)) else begin
            errors++;
            $error("[TB] FAIL %s ptr_o: got %0d expected %0d", tag, ptr_o, m_ptr);
        end
    endtask

    task automatic checkPtr(input string tag, input int exp);
        checks++;
        assert (ptr_o === 3'(exp)) else begin
            errors++;
            $error("[TB] FAIL %s ptr_o: got %0d expected %0d", tag, ptr_o, exp);
        end
    endtask

    task automatic updateFairness();
        for (int i = 0; i < SIZE; i++) begin
            if (!req_i[i] || grant_o[0][i] || grant_o[1][i]) begin
                wait_cnt[i] = 0;
            end else begin
                wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] req,
                                 input logic [1:0] gnt, input string tag);
        reset   = rst;
        rrEn_i  = en;
        req_i   = req;
        grant_i = gnt;
        #2;
        modelCompute(rst, en, req, gnt);
        checkOutput(tag);
        if (fair_on) updateFairness();
        @(posedge clk);
        #1;
        m_ptr = exp_next;
    endtask

    initial begin
        logic [7:0] fr;
        reset   = 1'b1;
        rrEn_i  = 1'b1;
        req_i   = '0;
        grant_i = '0;
        @(posedge clk);
        #1;
        m_ptr = 0;

        applyStimulus(1'b1, 1'b1, 8'hFF, 2'b11, "reset");
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'b11, "release");
        checkPtr("ptr_after_release", 2);
        applyStimulus(1'b0, 1'b1, 8'h30, 2'b11, "move_to_6");
        checkPtr("ptr_at_6", 6);
        applyStimulus(1'b0, 1'b1, 8'hC1, 2'b11, "wrap1");
        checkPtr("ptr_after_wrap1", 0);
        applyStimulus(1'b0, 1'b1, 8'hC1, 2'b11, "wrap2");
        checkPtr("ptr_after_wrap2", 7);
        applyStimulus(1'b0, 1'b1, 8'h80, 2'b01, "move_to_0");
        checkPtr("ptr_at_0", 0);
        applyStimulus(1'b0, 1'b1, 8'h0C, 2'b01, "partial");
        checkPtr("ptr_after_partial", 3);
        applyStimulus(1'b0, 1'b1, 8'h10, 2'b11, "sparse");
        checkPtr("ptr_after_sparse", 5);
        applyStimulus(1'b0, 1'b0, 8'h21, 2'b11, "fixed");
        checkPtr("ptr_hold_fixed", 5);
        applyStimulus(1'b0, 1'b1, 8'h21, 2'b11, "reenable");
        checkPtr("ptr_after_reenable", 1);
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b1, 8'hFF, 2'b00, "no_grant");
        checkPtr("ptr_hold_no_grant", 1);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
                          8'($urandom), 2'($urandom), "random");
        end

        for (int i = 0; i < SIZE; i++) wait_cnt[i] = 0;
        fair_on = 1'b1;
        fr = 8'($urandom);
        for (int n = 0; n < 400; n++) begin
            fr = (fr & 8'($urandom | $urandom)) | 8'($urandom & $urandom & $urandom);
            applyStimulus(1'b0, 1'b1, fr, 2'b11, "fairness");
        end
        fair_on = 1'b0;
        checks++;
        assert (max_wait <= (SIZE + NG - 1) / NG) else begin
            errors++;
            $error("[TB] FAIL fairness_bound: got wait %0d expected at most %0d",
                   max_wait, (SIZE + NG - 1) / NG);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
